axicb_skid_pipeline: RTL and testbench

- Parametrised valid/ready register pipeline for crossbar channels. Successor to the single-register pipeline stage.
- Adds a full-throughput skid-buffer mode with a registered i_ready, which breaks the combinational ready path. Adds an occupancy output.
- Inserted on any crossbar channel (AW/W/B/AR/R) or ECC datapath to close timing without losing bandwidth.

---
 rtl/axicb_skid_pipeline.sv | 220 ++++++++++++++++++++++
 tb/tb_axicb_skid_pipeline.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axicb_skid_pipeline.sv
// Purpose: cascade of NB_PIPELINE valid/ready register stages for crossbar channels; MODE 0 = forward register, MODE 1 = skid buffer.
// Latency: NB_PIPELINE cycles from input accept to o_valid; NB_PIPELINE=0 is a combinational passthrough.
// Backpressure: MODE 0 i_ready is combinational from o_ready; MODE 1 i_ready comes from a flop. Optional macro AXICB_PIPE_PARITY_EN adds carried parity and sticky o_parity_err.
module axicb_skid_pipeline #(
    parameter  int DATA_BUS_W  = 8,
    parameter  int NB_PIPELINE = 1,
    parameter  int MODE        = 1,
    localparam int CAP         = NB_PIPELINE * (MODE + 1),
    localparam int CNT_W       = (CAP > 0) ? $clog2(CAP + 1) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_BUS_W-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_BUS_W-1:0] o_data,
`ifdef AXICB_PIPE_PARITY_EN
    output logic                  o_parity_err,
`endif
    output logic [CNT_W-1:0]      o_count
);

`ifdef AXICB_PIPE_PARITY_EN
    localparam int PW = DATA_BUS_W + 1;
`else
    localparam int PW = DATA_BUS_W;
`endif

    // Handshake/payload at each stage boundary: index 0 is the pipeline input, NB_PIPELINE the output.
    logic [NB_PIPELINE:0] st_vld;
    logic [NB_PIPELINE:0] st_rdy;
    logic [PW-1:0]        st_dat [NB_PIPELINE+1];

    logic             in_acc;
    logic             out_take;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign st_vld[0] = i_valid;
    assign i_ready   = st_rdy[0];
`ifdef AXICB_PIPE_PARITY_EN
    assign st_dat[0] = {^i_data, i_data};
`else
    assign st_dat[0] = i_data;
`endif

    assign o_valid             = st_vld[NB_PIPELINE];
    assign o_data              = st_dat[NB_PIPELINE][DATA_BUS_W-1:0];
    assign st_rdy[NB_PIPELINE] = o_ready;

    for (genvar k = 0; k < NB_PIPELINE; k++) begin : g_stage
        if (MODE == 0) begin : g_fwd
            logic          vld_q;
            logic          vld_d;
            logic [PW-1:0] dat_q;
            logic [PW-1:0] dat_d;

            assign st_rdy[k]   = ~(vld_q & ~st_rdy[k+1]);
            assign st_vld[k+1] = vld_q;
            assign st_dat[k+1] = dat_q;

            // Refill whenever the slot is free or draining; data only changes on an accept.
            always_comb begin
                vld_d = vld_q;
                dat_d = dat_q;
                if (st_rdy[k]) begin
                    vld_d = st_vld[k];
                    if (st_vld[k]) begin
                        dat_d = st_dat[k];
                    end
                end
                if (srst) begin
                    vld_d = 1'b0;
                    dat_d = '0;
                end
            end

            // Stage register.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end
        end else begin : g_skid
            // Encoding chosen so bit0 = main valid and bit1 = skid valid, both straight from the flop.
            typedef enum logic [1:0] {
                ST_EMPTY = 2'b00,
                ST_BUSY  = 2'b01,
                ST_FULL  = 2'b11
            } state_t;

            state_t        state_q;
            state_t        state_d;
            logic [PW-1:0] main_dat_q;
            logic [PW-1:0] main_dat_d;
            logic [PW-1:0] skid_dat_q;
            logic [PW-1:0] skid_dat_d;
            logic          acc;
            logic          take;

            assign st_rdy[k]   = ~state_q[1];
            assign st_vld[k+1] = state_q[0];
            assign st_dat[k+1] = main_dat_q;
            assign acc         = st_vld[k] & ~state_q[1];
            assign take        = state_q[0] & st_rdy[k+1];

            // Next state: an accept during a stall parks the word in the skid register.
            always_comb begin
                state_d    = state_q;
                main_dat_d = main_dat_q;
                skid_dat_d = skid_dat_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (acc) begin
                            state_d    = ST_BUSY;
                            main_dat_d = st_dat[k];
                        end
                    end
                    ST_BUSY: begin
                        if (acc && take) begin
                            main_dat_d = st_dat[k];
                        end else if (acc) begin
                            state_d    = ST_FULL;
                            skid_dat_d = st_dat[k];
                        end else if (take) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (take) begin
                            state_d    = ST_BUSY;
                            main_dat_d = skid_dat_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                if (srst) begin
                    state_d    = ST_EMPTY;
                    main_dat_d = '0;
                    skid_dat_d = '0;
                end
            end

            // State and data registers.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    state_q    <= ST_EMPTY;
                    main_dat_q <= '0;
                    skid_dat_q <= '0;
                end else begin
                    state_q    <= state_d;
                    main_dat_q <= main_dat_d;
                    skid_dat_q <= skid_dat_d;
                end
            end
        end
    end

    assign in_acc   = i_valid & i_ready;
    assign out_take = o_valid & o_ready;

    // Occupancy: +1 per accept, -1 per take; with no stages both always coincide so it stays 0.
    always_comb begin
        count_d = count_q;
        if (in_acc && !out_take) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_acc && out_take) begin
            count_d = count_q - CNT_W'(1);
        end
        if (srst) begin
            count_d = '0;
        end
    end

    // Occupancy register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

`ifdef AXICB_PIPE_PARITY_EN
    logic par_err_q;
    logic par_err_d;

    // Sticky flag: set after any take whose carried parity disagrees with the delivered data.
    always_comb begin
        par_err_d = par_err_q;
        if (out_take && (st_dat[NB_PIPELINE][DATA_BUS_W] != ^o_data)) begin
            par_err_d = 1'b1;
        end
        if (srst) begin
            par_err_d = 1'b0;
        end
    end

    // Parity error register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign o_parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_axicb_skid_pipeline.sv
// Purpose: self-checking bench for axicb_skid_pipeline over five parameter sets driven side by side.
// Latency: reference is an ordered per-instance word list; occupancy = words in minus words out.
// Backpressure: random o_ready and AXI-style held i_valid; stall stability checked every cycle.
module tb_axicb_skid_pipeline;

    localparam int N = 5;
    localparam int NBS [N] = '{2, 3, 3, 0, 1};
    localparam int MDS [N] = '{1, 0, 1, 1, 1};

    logic aclk = 1'b0;
    logic aresetn;
    logic srst;

    logic [N-1:0]       iv, ir, ov, ordy;
    logic [N-1:0][7:0]  id, od;
    logic [N-1:0][31:0] cnt;
`ifdef AXICB_PIPE_PARITY_EN
    logic [N-1:0]       pe;
`endif

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CAP = NBS[g] * (MDS[g] + 1);
        localparam int CW  = (CAP > 0) ? $clog2(CAP + 1) : 1;
        logic [CW-1:0] c;
        axicb_skid_pipeline #(.DATA_BUS_W(8), .NB_PIPELINE(NBS[g]), .MODE(MDS[g])) u_dut (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .i_valid (iv[g]),
            .i_ready (ir[g]),
            .i_data  (id[g]),
            .o_valid (ov[g]),
            .o_ready (ordy[g]),
            .o_data  (od[g]),
`ifdef AXICB_PIPE_PARITY_EN
            .o_parity_err (pe[g]),
`endif
            .o_count (c)
        );
        assign cnt[g] = 32'(c);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cap_of(input int g);
        return NBS[g] * (MDS[g] + 1);
    endfunction

    // Reference: every accepted word, in order; read pointer advances on each take.
    logic [7:0] mq [N][4096];
    int         wp [N];
    int         rp [N];
    logic       hold [N];
    logic       prev_stall [N];
    logic [7:0] prev_od [N];

    task automatic model_clear();
        for (int g = 0; g < N; g++) begin
            wp[g] = 0; rp[g] = 0; hold[g] = 1'b0; prev_stall[g] = 1'b0; prev_od[g] = 8'h00;
        end
    endtask

    task automatic idle_all();
        iv = '0; id = '0;
    endtask

    task automatic chk_cleared(input string tag, input int g);
        chk({tag, "_vld"}, 32'(ov[g]), 0);
        chk({tag, "_dat"}, 32'(od[g]), 0);
        chk({tag, "_cnt"}, cnt[g], 0);
        chk({tag, "_rdy"}, 32'(ir[g]), 1);
    endtask

    logic [7:0] t2w [3];
    int ip, op;
    logic acc_h, tk_h;

    initial begin
        aresetn = 1'b0; srst = 1'b0;
        idle_all();
        ordy = '0;
        model_clear();
        repeat (3) @(posedge aclk);
        #1;
        // Reset state of every instance (pass-through instance follows its inputs).
        for (int g = 0; g < N; g++) begin
            chk("rst_vld", 32'(ov[g]), 0);
            chk("rst_dat", 32'(od[g]), 0);
            chk("rst_cnt", cnt[g], 0);
            chk("rst_rdy", 32'(ir[g]), (NBS[g] > 0) ? 1 : 0);
        end
        aresetn = 1'b1;
        ordy = '1;

        // Back-to-back burst through 2 skid stages: 2-cycle latency, no ready drop.
        for (int c = 0; c < 19; c++) begin
            @(posedge aclk); #1;
            iv[0] = (c < 16);
            id[0] = 8'(c + 1);
            @(negedge aclk);
            if (c < 16) chk("t1_rdy", 32'(ir[0]), 1);
            chk("t1_vld", 32'(ov[0]), (c >= 2 && c < 18) ? 1 : 0);
            if (c >= 2 && c < 18) chk("t1_dat", 32'(od[0]), 32'(c - 1));
        end

        // Single skid stage under stall: two words absorbed, third held off, then drained in order.
        t2w[0] = 8'hA1; t2w[1] = 8'hA2; t2w[2] = 8'hA3;
        ip = 0; op = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge aclk); #1;
            ordy[4] = (c >= 4);
            iv[4]   = (ip < 3);
            id[4]   = (ip < 3) ? t2w[ip] : 8'h00;
            @(negedge aclk);
            if (c == 0 || c == 1) chk("t2_rdy_open", 32'(ir[4]), 1);
            if (c == 2 || c == 3) begin
                chk("t2_rdy_full", 32'(ir[4]), 0);
                chk("t2_cnt", cnt[4], 2);
            end
            if (c >= 1 && c <= 3) begin
                chk("t2_vld_hold", 32'(ov[4]), 1);
                chk("t2_dat_hold", 32'(od[4]), 32'hA1);
            end
            if (ov[4] && ordy[4]) begin
                chk("t2_order", 32'(od[4]), (op < 3) ? 32'(t2w[op]) : 32'hFFFF);
                op++;
            end
            if (iv[4] && ir[4]) ip++;
        end
        chk("t2_words_in", 32'(ip), 3);
        chk("t2_words_out", 32'(op), 3);
        idle_all();

        // Fill 2 skid stages, then synchronous reset.
        for (int c = 0; c < 6; c++) begin
            @(posedge aclk); #1;
            ordy[0] = 1'b0;
            iv[0] = 1'b1;
            id[0] = 8'(8'h30 + c);
        end
        @(posedge aclk); #1;
        chk("t4_full_cnt", cnt[0], 4);
        chk("t4_full_rdy", 32'(ir[0]), 0);
        chk("t4_full_vld", 32'(ov[0]), 1);
        srst = 1'b1;
        idle_all();
        @(posedge aclk); #1;
        srst = 1'b0;
        chk_cleared("t4_srst", 0);

        // Asynchronous reset in the middle of a flowing burst.
        ordy[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge aclk); #1;
            iv[0] = 1'b1;
            id[0] = 8'(8'h60 + c);
        end
        #2 aresetn = 1'b0;
        #1 chk_cleared("t4_arst", 0);
        idle_all();
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Zero-stage instance is a wire.
        ordy[3] = 1'b0; iv[3] = 1'b1; id[3] = 8'h5A;
        #1;
        chk("t5_vld", 32'(ov[3]), 1);
        chk("t5_dat", 32'(od[3]), 32'h5A);
        chk("t5_rdy0", 32'(ir[3]), 0);
        ordy[3] = 1'b1;
        #1;
        chk("t5_rdy1", 32'(ir[3]), 1);
        iv[3] = 1'b0;
        #1;
        chk("t5_vld0", 32'(ov[3]), 0);
        chk("t5_cnt", cnt[3], 0);

        // Random traffic on all instances against the ordered word list.
        @(posedge aclk); #1;
        srst = 1'b1; idle_all();
        @(posedge aclk); #1;
        srst = 1'b0;
        model_clear();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge aclk); #1;
            for (int g = 0; g < N; g++) begin
                chk("rnd_cnt", cnt[g], 32'(wp[g] - rp[g]));
                chk("rnd_cap", 32'(cnt[g] <= 32'(cap_of(g))), 1);
                if (NBS[g] > 0 && cnt[g] == 0) chk("rnd_empty_vld", 32'(ov[g]), 0);
                if (MDS[g] == 1 && NBS[g] > 0 && cnt[g] == 32'(cap_of(g)))
                    chk("rnd_full_rdy", 32'(ir[g]), 0);
                if (!hold[g]) begin
                    iv[g] = ($urandom_range(0, 9) < 7);
                    id[g] = 8'($urandom);
                end
                ordy[g] = 1'($urandom_range(0, 1));
            end
            @(negedge aclk);
            for (int g = 0; g < N; g++) begin
                if (NBS[g] == 0) begin
                    chk("rnd_pt_vld", 32'(ov[g]), 32'(iv[g]));
                    chk("rnd_pt_dat", 32'(od[g]), 32'(id[g]));
                    chk("rnd_pt_rdy", 32'(ir[g]), 32'(ordy[g]));
                end
                if (prev_stall[g]) begin
                    chk("rnd_stall_vld", 32'(ov[g]), 1);
                    chk("rnd_stall_dat", 32'(od[g]), 32'(prev_od[g]));
                end
                acc_h = iv[g] & ir[g];
                tk_h  = ov[g] & ordy[g];
                if (acc_h && NBS[g] == 0) begin
                    mq[g][wp[g] % 4096] = id[g]; wp[g]++;
                end
                if (tk_h) begin
                    if (rp[g] == wp[g]) chk("rnd_spurious", 1, 0);
                    else begin
                        chk("rnd_data", 32'(od[g]), 32'(mq[g][rp[g] % 4096]));
                        rp[g]++;
                    end
                end
                if (acc_h && NBS[g] != 0) begin
                    mq[g][wp[g] % 4096] = id[g]; wp[g]++;
                end
                hold[g]       = iv[g] & ~ir[g];
                prev_stall[g] = ov[g] & ~ordy[g];
                prev_od[g]    = od[g];
            end
        end
        chk("rnd_words_m0", 32'(rp[1] >= 1000), 1);
        chk("rnd_words_m1", 32'(rp[2] >= 1000), 1);

`ifdef AXICB_PIPE_PARITY_EN
        for (int g = 0; g < N; g++) chk("par_clean", 32'(pe[g]), 0);
        @(posedge aclk); #1;
        srst = 1'b1; idle_all(); ordy = '0;
        @(posedge aclk); #1;
        srst = 1'b0;
        iv[4] = 1'b1; id[4] = 8'h55;
        @(posedge aclk); #1;
        iv[4] = 1'b0;
        force g_dut[4].u_dut.g_stage[0].g_skid.main_dat_q = 9'h054;
        #1 ordy[4] = 1'b1;
        @(negedge aclk);
        chk("par_before", 32'(pe[4]), 0);
        @(posedge aclk); #1;
        release g_dut[4].u_dut.g_stage[0].g_skid.main_dat_q;
        ordy[4] = 1'b0;
        chk("par_set", 32'(pe[4]), 1);
        repeat (3) @(posedge aclk);
        #1 chk("par_sticky", 32'(pe[4]), 1);
        srst = 1'b1;
        @(posedge aclk); #1;
        srst = 1'b0;
        chk("par_clr", 32'(pe[4]), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
